// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: opcodes, fetch FSM encoding, NOP word.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_REQ  = 3'd1,
    FS_WAIT = 3'd2,
    FS_HOLD = 3'd3,
    FS_DROP = 3'd4
  } fetch_state_t;

  function automatic logic is_jump(input logic [31:0] word);
    return (word[31:26] == OP_J) || (word[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry word+pc register that parks a fetched word while the IF/ID register is stalled.
module fetch_hold_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] word_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] word,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= NOP_WORD;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/rsp handshake, fills IF/ID.
// Optional INSTR_FETCH_EARLY_JUMP_EN: J/JAL targets are followed at fetch time.
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         ifid_free;
  logic         hold_load, hold_drain;
  logic         hold_valid;
  logic [31:0]  hold_word, hold_pc;

  assign pc_plus4  = pc + 32'd4;
  assign ifid_free = !if_valid || !stall;

`ifdef INSTR_FETCH_EARLY_JUMP_EN
  assign next_pc = is_jump(imem_rsp_data) ?
                   {pc_plus4[31:28], imem_rsp_data[25:0], 2'b00} : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  // Request side decodes straight from registers, so stall/redirect never reach it.
  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc;

  assign hold_load  = !redirect_valid && (state == FS_WAIT) && imem_rsp_valid && !ifid_free;
  assign hold_drain = !redirect_valid && (state == FS_HOLD) && !stall && hold_valid;

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .drain   (hold_drain),
    .clear   (redirect_valid),
    .word_in (imem_rsp_data),
    .pc_in   (pc),
    .valid   (hold_valid),
    .word    (hold_word),
    .pc      (hold_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FS_IDLE;
      pc             <= RESET_PC & PC_ALIGN;
      if_valid       <= 1'b0;
      if_instruction <= NOP_WORD;
      if_pc          <= 32'h0;
      if_pc_plus4    <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & PC_ALIGN;
      if_valid <= 1'b0;
      // An accepted request whose response is still outstanding must be drained first.
      if ((state == FS_WAIT && !imem_rsp_valid) || (state == FS_REQ && imem_req_ready))
        state <= FS_DROP;
      else
        state <= FS_REQ;
    end else begin
      if (if_valid && !stall) if_valid <= 1'b0;
      case (state)
        FS_IDLE: state <= FS_REQ;
        FS_REQ:  if (imem_req_ready) state <= FS_WAIT;
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            pc <= next_pc;
            if (ifid_free) begin
              if_valid       <= 1'b1;
              if_instruction <= imem_rsp_data;
              if_pc          <= pc;
              if_pc_plus4    <= pc_plus4;
              state          <= FS_REQ;
            end else begin
              state <= FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (hold_drain) begin
            if_valid       <= 1'b1;
            if_instruction <= hold_word;
            if_pc          <= hold_pc;
            if_pc_plus4    <= hold_pc + 32'd4;
            state          <= FS_REQ;
          end
        end
        FS_DROP: if (imem_rsp_valid) state <= FS_REQ;
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus a randomized run
// checked against an in-order fetch-stream model.
module tb_instr_fetch_stage;

`ifdef INSTR_FETCH_EARLY_JUMP_EN
  localparam bit EJ = 1'b1;
`else
  localparam bit EJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;

  int n_run = 0;
  int n_fail = 0;

  bit          mem_rand = 1'b0;
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2008_0005;
    if (a == 32'h0000_0004) return 32'h2108_0004;
    if (a == 32'h0000_0010) return 32'h0800_0040;
    if (a == 32'hFFFF_FFFC) return 32'h2108_0001;
    return (a * 32'h9E37_79B1) ^ 32'h3C5A_A5C3;
  endfunction

  // Memory: one outstanding request, response latency counted in cycles after accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end else cnt--;
      end
      imem_req_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (imem_req_valid && imem_req_ready && !pend) begin
        pend = 1'b1;
        pend_addr = imem_req_addr;
        cnt = mem_rand ? int'($urandom_range(0, 2)) : mem_lat - 1;
      end
    end
  end

  task automatic wait_req(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_load(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (if_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_run++;
    if ({if_valid, imem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valids got %b want 00", {if_valid, imem_req_valid});
    end
    n_run++;
    if ({if_instruction, if_pc, if_pc_plus4} !== 96'h0) begin
      n_fail++; $display("FAIL reset_ifid got %h %h %h want 0", if_instruction, if_pc, if_pc_plus4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL zw_first_req got %b/%h want 1/0", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    n_run++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL zw_early_valid got %b want 0", if_valid); end
    @(negedge clk);
    n_run++;
    if ({if_valid, if_pc, if_pc_plus4, if_instruction} !== {1'b1, 32'h0, 32'h4, 32'h2008_0005}) begin
      n_fail++; $display("FAIL zw_ifid got %b %h %h %h want 1 0 4 20080005", if_valid, if_pc, if_pc_plus4, if_instruction);
    end
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL zw_next_req got %b/%h want 1/4", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_run++;
      if ({if_valid, if_pc, imem_req_valid} !== {1'b1, 32'h0, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d] got %b %h %b want 1 0 0", i, if_valid, if_pc, imem_req_valid);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_run++;
    if ({if_valid, if_pc, if_pc_plus4, if_instruction} !== {1'b1, 32'h4, 32'h8, mem_word(32'h4)}) begin
      n_fail++; $display("FAIL stall_release got %b %h %h %h want 1 4 8 %h", if_valid, if_pc, if_pc_plus4, if_instruction, mem_word(32'h4));
    end
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin
      n_fail++; $display("FAIL stall_next_req got %b/%h want 1/8", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    n_run++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup got %b want 0", if_valid); end
    @(negedge clk);
    n_run++;
    if ({if_valid, if_pc} !== {1'b1, 32'h8}) begin
      n_fail++; $display("FAIL stall_after got %b %h want 1 8", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    wait_req(20, ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL rw_timeout got none want req"); return; end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_run++;
    if ({if_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL rw_restart got %b %b %h want 0 1 100", if_valid, imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    n_run++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_gap got %b want 0", if_valid); end
    @(negedge clk);
    n_run++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
      n_fail++; $display("FAIL rw_new got %b %h %h want 1 100 %h", if_valid, if_pc, if_instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_drop();
    bit ok;
    mem_lat = 3;
    wait_req(20, ok);
    n_run++;
    if (!ok) begin n_fail++; $display("FAIL drop_timeout got none want req"); mem_lat = 1; return; end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_run++;
    if ({if_valid, imem_req_valid} !== 2'b00) begin
      n_fail++; $display("FAIL drop_wait1 got %b%b want 00", if_valid, imem_req_valid);
    end
    @(negedge clk);
    n_run++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drop_wait2 got %b want 0", imem_req_valid); end
    @(negedge clk);
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL drop_restart got %b/%h want 1/200", imem_req_valid, imem_req_addr);
    end
    wait_load(20, ok);
    n_run++;
    if ({ok, if_pc, if_instruction} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      n_fail++; $display("FAIL drop_new got %b %h %h want 1 200 %h", ok, if_pc, if_instruction, mem_word(32'h200));
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_stall();
    bit ok;
    wait_load(20, ok);
    stall = 1'b1;
    @(negedge clk);
    n_run++;
    if ({ok, if_valid} !== 2'b11) begin n_fail++; $display("FAIL rs_pre got %b%b want 11", ok, if_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    n_run++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_flush got %b want 0", if_valid); end
    wait_load(20, ok);
    n_run++;
    if ({ok, if_pc} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL rs_restart got %b %h want 1 40", ok, if_pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_load(20, ok);
    n_run++;
    if ({ok, if_pc, if_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++; $display("FAIL wrap_ifid got %b %h %h want 1 fffffffc 0", ok, if_pc, if_pc_plus4);
    end
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_req got %b/%h want 1/0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_early_jump();
    bit ok;
    logic [31:0] want;
    want = EJ ? 32'h0000_0100 : 32'h0000_0014;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_load(20, ok);
    n_run++;
    if ({ok, if_pc, if_pc_plus4, if_instruction} !== {1'b1, 32'h10, 32'h14, 32'h0800_0040}) begin
      n_fail++; $display("FAIL ej_ifid got %b %h %h %h want 1 10 14 08000040", ok, if_pc, if_pc_plus4, if_instruction);
    end
    n_run++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, want}) begin
      n_fail++; $display("FAIL ej_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, want);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({if_valid, imem_req_valid, if_pc, if_instruction} !== 66'h0) begin
      n_fail++; $display("FAIL reset_mid got %b %b %h %h want 0", if_valid, imem_req_valid, if_pc, if_instruction);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model: the decoder sees consecutive words from the current fetch address,
  // restarting at every redirect; each word equals memory at its address.
  task automatic test_random();
    logic [31:0] exp_pc, w, nxt;
    int ncons = 0;
    exp_pc = 32'h0;
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      if (redirect_valid) begin
        redirect_pc = $urandom;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (if_valid && !stall) begin
        w = mem_word(exp_pc);
        nxt = exp_pc + 32'd4;
        n_run++;
        if ({if_pc, if_instruction, if_pc_plus4} !== {exp_pc, w, nxt}) begin
          n_fail++; $display("FAIL rand_stream[%0d] got %h %h %h want %h %h %h", ncons, if_pc, if_instruction, if_pc_plus4, exp_pc, w, nxt);
        end
        if (EJ && (w[31:26] == 6'b000010 || w[31:26] == 6'b000011)) exp_pc = {nxt[31:28], w[25:0], 2'b00};
        else exp_pc = nxt;
        ncons++;
      end
      @(negedge clk);
    end
    stall = 1'b0; redirect_valid = 1'b0; mem_rand = 1'b0;
    n_run++;
    if (ncons < 100) begin n_fail++; $display("FAIL rand_progress got %0d want >=100", ncons); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_drop();
    test_redirect_stall();
    test_wrap();
    test_early_jump();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
